// File: rtl/tb_status_pkg.sv
// Shared constants and types for the testbench status responder.
// Register offsets are word indices (addr[4:2]) within the 32-byte window.
package tb_status_pkg;

    localparam logic [2:0] OFF_STDOUT = 3'd0;
    localparam logic [2:0] OFF_STATUS = 3'd1;
    localparam logic [2:0] OFF_EXIT   = 3'd2;
    localparam logic [2:0] OFF_CYCLE  = 3'd3;
    localparam logic [2:0] OFF_LEVEL  = 3'd4;
    localparam logic [2:0] OFF_WDOG   = 3'd5;

    localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'd123456789;
    localparam logic [31:0] DEFAULT_FAIL_MAGIC = 32'd1;
    localparam logic [31:0] WDOG_EXIT_CODE     = 32'hDEAD_0001;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/tb_status_fifo.sv
// Synchronous FIFO for stdout characters; push while full and pop while empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module tb_status_fifo #(
    parameter int  DEPTH  = 8,
    parameter int  DATA_W = 8,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tb_status_responder.sv
// OBI-style responder providing stdout FIFO, pass/fail/exit events and a cycle counter.
// Optional watchdog timeout register enabled by defining TB_STATUS_WATCHDOG_EN.
module tb_status_responder
    import tb_status_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = DEFAULT_PASS_MAGIC,
    parameter logic [31:0] FAIL_MAGIC = DEFAULT_FAIL_MAGIC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        stdout_valid_o,
    output logic [7:0]  stdout_data_o,
    input  logic        stdout_ready_i,
    output logic        tests_passed_o,
    output logic        tests_failed_o,
    output logic        exit_valid_o,
    output logic [31:0] exit_value_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          hit;
    logic [2:0]    off;
    logic          stdout_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_rdata;
    logic          fifo_pop;
    logic          push_sel;
    logic          status_sel;
    logic          exit_sel;
    logic          wdog_sel;
    logic          err_sel;
    logic [31:0]   rd_data;
    logic          wdog_trip;
    logic [31:0]   wdog_limit;
    logic [31:0]   cycle;
    rsp_t          rsp;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^data_addr_i[1:0];

    assign hit        = (data_addr_i[31:5] == BASE_ADDR[31:5]);
    assign off        = data_addr_i[4:2];
    assign stdout_wr  = data_req_i && hit && data_we_i && (off == OFF_STDOUT);
    // A full FIFO stalls the master instead of dropping the character.
    assign data_gnt_o = data_req_i && !(stdout_wr && fifo_full);
    assign fifo_pop   = !fifo_empty && stdout_ready_i;

    always_comb begin
        push_sel   = 1'b0;
        status_sel = 1'b0;
        exit_sel   = 1'b0;
        wdog_sel   = 1'b0;
        err_sel    = 1'b0;
        rd_data    = '0;
        if (!hit) begin
            err_sel = 1'b1;
        end else if (data_we_i) begin
            case (off)
                OFF_STDOUT: if (data_be_i[0])       push_sel   = 1'b1; else err_sel = 1'b1;
                OFF_STATUS: if (data_be_i == 4'hF)  status_sel = 1'b1; else err_sel = 1'b1;
                OFF_EXIT:   if (data_be_i == 4'hF)  exit_sel   = 1'b1; else err_sel = 1'b1;
`ifdef TB_STATUS_WATCHDOG_EN
                OFF_WDOG:   if (data_be_i == 4'hF)  wdog_sel   = 1'b1; else err_sel = 1'b1;
`endif
                default:    err_sel = 1'b1;
            endcase
        end else begin
            case (off)
                OFF_CYCLE: rd_data = cycle;
                OFF_LEVEL: rd_data = 32'(fifo_count);
`ifdef TB_STATUS_WATCHDOG_EN
                OFF_WDOG:  rd_data = wdog_limit;
`endif
                default:   rd_data = '0;
            endcase
        end
    end

    tb_status_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (8)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (data_gnt_o && push_sel),
        .pop   (fifo_pop),
        .wdata (data_wdata_i[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

`ifdef TB_STATUS_WATCHDOG_EN
    logic wdog_fired;

    assign wdog_trip = (wdog_limit != '0) && (cycle >= wdog_limit) && !wdog_fired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog_limit <= '0;
            wdog_fired <= 1'b0;
        end else begin
            if (data_gnt_o && wdog_sel) wdog_limit <= data_wdata_i;
            if (wdog_trip)              wdog_fired <= 1'b1;
        end
    end
`else
    assign wdog_trip  = 1'b0;
    assign wdog_limit = '0;
    logic unused_wdog_sel;
    assign unused_wdog_sel = wdog_sel ^ ^wdog_limit;
`endif

    // Response stage: one registered response per granted request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp            <= '0;
            cycle          <= '0;
            tests_passed_o <= 1'b0;
            tests_failed_o <= 1'b0;
            exit_valid_o   <= 1'b0;
            exit_value_o   <= '0;
        end else begin
            rsp.rvalid     <= data_gnt_o;
            rsp.rdata      <= data_gnt_o ? rd_data : '0;
            rsp.err        <= data_gnt_o && err_sel;
            cycle          <= cycle + 32'd1;
            tests_passed_o <= data_gnt_o && status_sel && (data_wdata_i == PASS_MAGIC);
            tests_failed_o <= (data_gnt_o && status_sel && (data_wdata_i == FAIL_MAGIC)) || wdog_trip;
            exit_valid_o   <= (data_gnt_o && exit_sel) || wdog_trip;
            if (wdog_trip)                  exit_value_o <= WDOG_EXIT_CODE;
            else if (data_gnt_o && exit_sel) exit_value_o <= data_wdata_i;
        end
    end

    assign data_rvalid_o  = rsp.rvalid;
    assign data_rdata_o   = rsp.rdata;
    assign data_err_o     = rsp.err;
    assign stdout_valid_o = !fifo_empty;
    assign stdout_data_o  = fifo_empty ? 8'h00 : fifo_rdata;

endmodule

// File: tb/tb_tb_status_responder.sv
// Self-checking bench: directed scenarios plus randomized bus/consumer traffic against a queue-based model.
// Define TB_STATUS_WATCHDOG_EN for both bench and RTL to exercise the watchdog register.
module tb_tb_status_responder;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          DEPTH = 8;
    localparam logic [31:0] PASS  = 32'd123456789;
    localparam logic [31:0] FAILV = 32'd1;
    localparam logic [31:0] DEAD  = 32'hDEAD_0001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        gnt;
    logic [31:0] addr = '0;
    logic        we = 1'b0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        sv;
    logic [7:0]  sd;
    logic        ready = 1'b0;
    logic        passed;
    logic        failed;
    logic        xvalid;
    logic [31:0] xvalue;

    int checks = 0;
    int errors = 0;
    logic checking = 1'b0;

    tb_status_responder dut (
        .clk_i(clk), .rst_i(rst), .data_req_i(req), .data_gnt_o(gnt),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err),
        .stdout_valid_o(sv), .stdout_data_o(sd), .stdout_ready_i(ready),
        .tests_passed_o(passed), .tests_failed_o(failed),
        .exit_valid_o(xvalid), .exit_value_o(xvalue)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  q[$];
    logic [31:0] cyc = '0;
    logic [31:0] wlimit = '0;
    logic        wfired = 1'b0;
    logic        exp_rvalid = 1'b0, exp_err = 1'b0, exp_pass = 1'b0, exp_fail = 1'b0, exp_xvalid = 1'b0;
    logic [31:0] exp_rdata = '0, exp_xvalue = '0;

    function automatic logic model_gnt();
        return req && !((addr[31:5] == BASE[31:5]) && we && (addr[4:2] == 3'd0) && (q.size() == DEPTH));
    endfunction

    always @(posedge clk) begin
        logic g, hit, push, trip;
        logic [2:0] off;
        logic [31:0] lvl, new_limit;
        if (rst) begin
            q.delete();
            cyc = '0; wlimit = '0; wfired = 1'b0;
            exp_rvalid = 0; exp_err = 0; exp_pass = 0; exp_fail = 0; exp_xvalid = 0;
            exp_rdata = '0; exp_xvalue = '0;
        end else begin
            hit = (addr[31:5] == BASE[31:5]);
            off = addr[4:2];
            lvl = q.size();
            g = model_gnt();
            push = 0; new_limit = wlimit;
            exp_rvalid = g; exp_rdata = '0; exp_err = 0;
            exp_pass = 0; exp_fail = 0; exp_xvalid = 0;
            if (g) begin
                if (!hit) exp_err = 1;
                else if (we) begin
                    case (off)
                        3'd0: if (be[0]) push = 1; else exp_err = 1;
                        3'd1: if (be == 4'hF) begin
                                  exp_pass = (wdata == PASS);
                                  exp_fail = (wdata == FAILV);
                              end else exp_err = 1;
                        3'd2: if (be == 4'hF) begin exp_xvalid = 1; exp_xvalue = wdata; end
                              else exp_err = 1;
`ifdef TB_STATUS_WATCHDOG_EN
                        3'd5: if (be == 4'hF) new_limit = wdata; else exp_err = 1;
`endif
                        default: exp_err = 1;
                    endcase
                end else begin
                    case (off)
                        3'd3: exp_rdata = cyc;
                        3'd4: exp_rdata = lvl;
`ifdef TB_STATUS_WATCHDOG_EN
                        3'd5: exp_rdata = wlimit;
`endif
                        default: exp_rdata = '0;
                    endcase
                end
            end
`ifdef TB_STATUS_WATCHDOG_EN
            trip = (wlimit != 0) && (cyc >= wlimit) && !wfired;
`else
            trip = 0;
`endif
            if (trip) begin
                exp_fail = 1; exp_xvalid = 1; exp_xvalue = DEAD; wfired = 1;
            end
            wlimit = new_limit;
            if (lvl > 0 && ready) void'(q.pop_front());
            if (push) q.push_back(wdata[7:0]);
            cyc = cyc + 32'd1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (checking) begin
            check("gnt", gnt, model_gnt());
            check("rvalid", rvalid, exp_rvalid);
            if (exp_rvalid) begin
                check("rdata", rdata, exp_rdata);
                check("err", err, exp_err);
            end
            check("passed", passed, exp_pass);
            check("failed", failed, exp_fail);
            check("exit_valid", xvalid, exp_xvalid);
            check("exit_value", xvalue, exp_xvalue);
            check("stdout_valid", sv, q.size() > 0);
            if (q.size() > 0) check("stdout_data", sd, q[0]);
        end
    end

    // ---------------- directed helpers ----------------
    task automatic bus_xfer(input logic [31:0] a, input logic w, input logic [3:0] b,
                            input logic [31:0] d, output logic [31:0] rd, output logic er);
        int n = 0;
        @(posedge clk); #1;
        req = 1; addr = a; we = w; be = b; wdata = d;
        @(negedge clk);
        while (!gnt && n < 200) begin @(negedge clk); n++; end
        if (!gnt) check("gnt_timeout", gnt, 1);
        @(posedge clk); #1;
        req = 0;
        @(negedge clk);
        check("xfer_rvalid", rvalid, 1);
        rd = rdata; er = err;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r1, r2;
        logic e;
        logic [7:0] got[$];
        logic [7:0] c;
        int n, pulses, rdy_pct;
        logic g;

        repeat (3) @(posedge clk);
        #1 rst = 0; checking = 1;
        @(negedge clk);
        check("reset_exit_value", xvalue, 0);
        check("reset_stdout_valid", sv, 0);
        check("reset_rvalid", rvalid, 0);

        // Pass magic
        bus_xfer(BASE + 32'h4, 1, 4'hF, PASS, r1, e);
        check("pass_err", e, 0);
        check("pass_pulse", passed, 1);
        @(negedge clk);
        check("pass_pulse_end", passed, 0);

        // Exit code and cycle counter
        bus_xfer(BASE + 32'h8, 1, 4'hF, 32'd5, r1, e);
        check("exit_pulse", xvalid, 1);
        check("exit_value", xvalue, 5);
        @(negedge clk);
        check("exit_pulse_end", xvalid, 0);
        check("exit_value_held", xvalue, 5);
        bus_xfer(BASE + 32'hC, 0, 4'hF, 0, r1, e);
        bus_xfer(BASE + 32'hC, 0, 4'hF, 0, r2, e);
        check("cycle_step", r2 - r1, 2);

        // Stdout backpressure
        ready = 0;
        c = 8'h41;
        for (int i = 0; i < 8; i++) begin
            bus_xfer(BASE, 1, 4'hF, {24'h0, c}, r1, e);
            check("stdout_wr_err", e, 0);
            c = c + 8'd1;
        end
        bus_xfer(BASE + 32'h10, 0, 4'hF, 0, r1, e);
        check("level_full", r1, 8);
        @(posedge clk); #1;
        req = 1; addr = BASE; we = 1; be = 4'hF; wdata = 32'h49;
        repeat (3) begin @(negedge clk); check("blocked_gnt", gnt, 0); end
        check("head_A", sd, 8'h41);
        ready = 1;
        @(posedge clk); #1; ready = 0;
        @(negedge clk); check("unblocked_gnt", gnt, 1);
        @(posedge clk); #1; req = 0; ready = 1;
        n = 0;
        while (got.size() < 8 && n < 50) begin
            @(negedge clk);
            if (sv) got.push_back(sd);
            n++;
        end
        ready = 0;
        check("drain_count", got.size(), 8);
        for (int i = 0; i < got.size(); i++) check("drain_char", got[i], 8'h42 + i);

        // Error responses
        bus_xfer(BASE + 32'hC, 1, 4'hF, 32'd7, r1, e);
        check("cycle_write_err", e, 1);
        bus_xfer(32'h2000_0000, 0, 4'hF, 0, r1, e);
        check("miss_err", e, 1);
        check("miss_rdata", r1, 0);
        bus_xfer(BASE + 32'h4, 1, 4'h3, PASS, r1, e);
        check("status_be_err", e, 1);
        check("status_be_nopulse", passed, 0);
        bus_xfer(BASE + 32'h14, 0, 4'hF, 0, r1, e);
        check("wdog_read", r1, 0);
        bus_xfer(BASE + 32'h14, 1, 4'hF, 0, r1, e);
`ifdef TB_STATUS_WATCHDOG_EN
        check("wdog_write_err", e, 0);
`else
        check("unlisted_write_err", e, 1);
`endif

        // Reset during a granted read
        bus_xfer(BASE, 1, 4'h1, 32'h5A, r1, e);
        @(posedge clk); #1;
        req = 1; addr = BASE + 32'hC; we = 0; be = 4'hF; rst = 1;
        @(negedge clk); check("rst_read_gnt", gnt, 1);
        @(posedge clk); #1; req = 0; rst = 0;
        @(negedge clk);
        check("rst_no_rvalid", rvalid, 0);
        check("rst_fifo_empty", sv, 0);
        check("rst_exit_value", xvalue, 0);

`ifdef TB_STATUS_WATCHDOG_EN
        bus_xfer(BASE + 32'h14, 1, 4'hF, 32'd50, r1, e);
        n = 0;
        while (!failed && n < 200) begin @(negedge clk); n++; end
        check("wdog_fail_pulse", failed, 1);
        check("wdog_exit_valid", xvalid, 1);
        check("wdog_exit_value", xvalue, DEAD);
        pulses = 0;
        repeat (100) begin @(negedge clk); if (failed) pulses++; end
        check("wdog_no_repeat", pulses, 0);
`endif

        // Randomized traffic
        rdy_pct = 50;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk); #1;
            if (i % 200 == 0) rdy_pct = ($urandom_range(0, 1) == 0) ? 10 : 90;
            ready = ($urandom_range(0, 99) < rdy_pct);
            rst = ($urandom_range(0, 599) == 0);
            if (!(req && !g)) begin
                req = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 9) != 0) addr = {BASE[31:5], 5'($urandom_range(0, 31))};
                else addr = $urandom;
                we = $urandom_range(0, 1);
                be = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom_range(0, 15));
                case ($urandom_range(0, 4))
                    0: wdata = PASS;
                    1: wdata = FAILV;
                    2, 3: wdata = 32'($urandom_range(0, 255));
                    default: wdata = $urandom;
                endcase
            end
        end
        @(posedge clk); #1;
        req = 0; rst = 0; ready = 1;
        repeat (20) @(negedge clk);
        checking = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
